// File: rtl/multi_palette.sv
// Multi-bank color palette: per-lane inferred RAM written a word at a time,
// a 2-stage valid/ready lookup pipeline, and frame-synchronised bank swapping.
module multi_palette #(
  parameter int PALETTE_LENGTH    = 256,
  parameter int COLOR_BITS        = 16,
  parameter int WR_DATA_BITS      = 32,
  parameter int NUM_BANKS         = 2,
  parameter int TRANSPARENT_INDEX = 0,
  localparam int CPW       = WR_DATA_BITS / COLOR_BITS,
  localparam int IDX_BITS  = $clog2(PALETTE_LENGTH),
  localparam int WA_BITS   = ($clog2(PALETTE_LENGTH / CPW) < 1) ? 1 : $clog2(PALETTE_LENGTH / CPW),
  localparam int BANK_BITS = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [CPW-1:0]          wr_en,
  input  logic [BANK_BITS-1:0]    wr_bank,
  input  logic [WA_BITS-1:0]      wr_addr,
  input  logic [WR_DATA_BITS-1:0] wr_data,
  input  logic                    swap_req,
  input  logic [BANK_BITS-1:0]    swap_bank,
  input  logic                    frame_start,
  input  logic                    transparent_en,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [IDX_BITS-1:0]     in_index,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [COLOR_BITS-1:0]   out_color,
  output logic                    out_transparent,
  output logic [BANK_BITS-1:0]    active_bank,
  output logic                    swap_pending
);

  // Each lane owns every CPW-th index, so a whole write word lands in one
  // address of CPW narrow RAMs and a lookup reads one word then picks a lane.
  localparam int LANE_DEPTH = PALETTE_LENGTH / CPW;
  localparam int RAM_DEPTH  = NUM_BANKS * LANE_DEPTH;
  localparam int RA_BITS    = ($clog2(RAM_DEPTH) < 1) ? 1 : $clog2(RAM_DEPTH);
  localparam int LANE_BITS  = ($clog2(CPW) < 1) ? 1 : $clog2(CPW);

  logic                         advance;
  logic                         accept;
  logic [RA_BITS-1:0]           ram_waddr;
  logic [RA_BITS-1:0]           ram_raddr;
  logic [LANE_BITS-1:0]         rd_lane;
  logic [CPW-1:0][COLOR_BITS-1:0] lane_rd;

  logic                  ready_q, ready_d;
  logic [BANK_BITS-1:0]  active_bank_q, active_bank_d;
  logic [BANK_BITS-1:0]  pend_bank_q, pend_bank_d;
  logic                  swap_pending_q, swap_pending_d;
  logic                  s1_valid_q, s1_valid_d;
  logic [LANE_BITS-1:0]  s1_lane_q, s1_lane_d;
  logic                  s1_transp_q, s1_transp_d;
  logic                  out_valid_q, out_valid_d;
  logic [COLOR_BITS-1:0] out_color_q, out_color_d;
  logic                  out_transp_q, out_transp_d;

  assign advance  = !out_valid_q || out_ready;
  assign in_ready = ready_q && advance;
  assign accept   = in_valid && in_ready;

  // The bank is folded into the RAM address at acceptance, so a later swap
  // cannot redirect a lookup that is already in flight.
  assign ram_waddr = RA_BITS'(int'(wr_bank) * LANE_DEPTH + int'(wr_addr));
  assign ram_raddr = RA_BITS'(int'(active_bank_q) * LANE_DEPTH + int'(in_index) / CPW);
  assign rd_lane   = LANE_BITS'(int'(in_index) % CPW);

  genvar gi;
  generate
    for (gi = 0; gi < CPW; gi++) begin : g_lane
      logic [COLOR_BITS-1:0] mem [0:RAM_DEPTH-1];
      logic [COLOR_BITS-1:0] rd_q;

      // Lane RAM: masked write, registered read that returns the old value on
      // a same-entry collision and holds while the pipeline is stalled.
      always_ff @(posedge clk) begin
        if (wr_en[gi]) begin
          mem[ram_waddr] <= wr_data[gi*COLOR_BITS +: COLOR_BITS];
        end
        if (advance) begin
          rd_q <= mem[ram_raddr];
        end
      end

      assign lane_rd[gi] = rd_q;
    end
  endgenerate

  // Next-state for pipeline stages and bank-swap bookkeeping.
  always_comb begin
    ready_d        = 1'b1;
    s1_valid_d     = s1_valid_q;
    s1_lane_d      = s1_lane_q;
    s1_transp_d    = s1_transp_q;
    out_valid_d    = out_valid_q;
    out_color_d    = out_color_q;
    out_transp_d   = out_transp_q;
    active_bank_d  = active_bank_q;
    pend_bank_d    = pend_bank_q;
    swap_pending_d = swap_pending_q;

    if (advance) begin
      s1_valid_d  = accept;
      s1_lane_d   = rd_lane;
      s1_transp_d = transparent_en && (in_index == IDX_BITS'(TRANSPARENT_INDEX));
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_color_d  = lane_rd[s1_lane_q];
        out_transp_d = s1_transp_q;
      end
    end

    if (swap_req && frame_start) begin
      active_bank_d  = swap_bank;
      pend_bank_d    = swap_bank;
      swap_pending_d = 1'b0;
    end else if (swap_req) begin
      pend_bank_d    = swap_bank;
      swap_pending_d = 1'b1;
    end else if (frame_start && swap_pending_q) begin
      active_bank_d  = pend_bank_q;
      swap_pending_d = 1'b0;
    end
  end

  // State registers; reset drops anything in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready_q        <= 1'b0;
      active_bank_q  <= '0;
      pend_bank_q    <= '0;
      swap_pending_q <= 1'b0;
      s1_valid_q     <= 1'b0;
      s1_lane_q      <= '0;
      s1_transp_q    <= 1'b0;
      out_valid_q    <= 1'b0;
      out_color_q    <= '0;
      out_transp_q   <= 1'b0;
    end else begin
      ready_q        <= ready_d;
      active_bank_q  <= active_bank_d;
      pend_bank_q    <= pend_bank_d;
      swap_pending_q <= swap_pending_d;
      s1_valid_q     <= s1_valid_d;
      s1_lane_q      <= s1_lane_d;
      s1_transp_q    <= s1_transp_d;
      out_valid_q    <= out_valid_d;
      out_color_q    <= out_color_d;
      out_transp_q   <= out_transp_d;
    end
  end

  assign out_valid       = out_valid_q;
  assign out_color       = out_color_q;
  assign out_transparent = out_transp_q;
  assign active_bank     = active_bank_q;
  assign swap_pending    = swap_pending_q;

endmodule

// File: tb/tb_multi_palette.sv
// Self-checking bench for multi_palette: directed scenarios plus a randomized
// run scored against a palette/queue reference model.
`timescale 1ns/1ps
module tb_multi_palette;
  localparam int PL = 256, CB = 16, WB = 32, NB = 2, CPW = 2;
  localparam int IDXB = 8, WAB = 7, BB = 1;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [CPW-1:0]  wr_en = '0;
  logic [BB-1:0]   wr_bank = '0;
  logic [WAB-1:0]  wr_addr = '0;
  logic [WB-1:0]   wr_data = '0;
  logic            swap_req = 1'b0;
  logic [BB-1:0]   swap_bank = '0;
  logic            frame_start = 1'b0;
  logic            transparent_en = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [IDXB-1:0] in_index = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [CB-1:0]   out_color;
  logic            out_transparent;
  logic [BB-1:0]   active_bank;
  logic            swap_pending;

  always #5 clk = ~clk;

  multi_palette dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr),
    .wr_data(wr_data), .swap_req(swap_req), .swap_bank(swap_bank),
    .frame_start(frame_start), .transparent_en(transparent_en), .in_valid(in_valid),
    .in_ready(in_ready), .in_index(in_index), .out_valid(out_valid), .out_ready(out_ready),
    .out_color(out_color), .out_transparent(out_transparent), .active_bank(active_bank),
    .swap_pending(swap_pending)
  );

  typedef struct packed { logic [CB-1:0] c; logic t; logic known; } exp_t;
  exp_t          exp_q[$];
  logic [CB-1:0] m_mem [NB*PL];
  bit            m_wr  [NB*PL];
  int            m_active = 0, m_pbank = 0;
  bit            m_pending = 0;
  int            n_checks = 0, n_pass = 0;

  // Advance one clock, updating the reference model from the inputs and
  // handshakes that the coming edge will act on.
  task automatic tick();
    exp_t e;
    int   ent;
    #1;
    if (out_valid && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
    if (in_valid && in_ready) begin
      ent     = m_active * PL + int'(in_index);
      e.c     = m_mem[ent];
      e.t     = transparent_en && (in_index == '0);
      e.known = m_wr[ent];
      exp_q.push_back(e);
    end
    for (int l = 0; l < CPW; l++) begin
      if (wr_en[l]) begin
        ent        = int'(wr_bank) * PL + int'(wr_addr) * CPW + l;
        m_mem[ent] = wr_data[l*CB +: CB];
        m_wr[ent]  = 1'b1;
      end
    end
    if (!reset) begin
      if (swap_req && frame_start) begin
        m_active = int'(swap_bank); m_pending = 0;
      end else if (swap_req) begin
        m_pbank = int'(swap_bank); m_pending = 1;
      end else if (frame_start && m_pending) begin
        m_active = m_pbank; m_pending = 0;
      end
    end
    @(posedge clk); #1;
  endtask

  // Issue one lookup with out_ready high and return the observed result.
  task automatic lookup(input int idx, output logic [CB-1:0] c, output logic t, output bit ok);
    ok = 0; c = '0; t = 1'b0;
    out_ready = 1'b1; in_valid = 1'b1; in_index = IDXB'(idx);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (out_valid) begin c = out_color; t = out_transparent; ok = 1; end
      tick();
    end
    $display("lookup idx=%0d bank=%0d -> color=%h transparent=%0b", idx, active_bank, c, t);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    n_checks++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready got=%b want=0", in_ready); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b want=0", out_valid); else n_pass++;
    n_checks++; if ({active_bank, swap_pending} !== 2'b00)
      $display("FAIL reset_bank got=%b/%b want=0/0", active_bank, swap_pending); else n_pass++;
    n_checks++; if ({out_color, out_transparent} !== 17'h0)
      $display("FAIL reset_out_data got=%h/%b want=0/0", out_color, out_transparent); else n_pass++;
    reset = 1'b0;
    tick();
    n_checks++; if (in_ready !== 1'b1) $display("FAIL release_in_ready got=%b want=1", in_ready); else n_pass++;
  endtask

  task automatic test_write_lanes();
    logic [CPW-1:0] en_t [2] = '{2'b11, 2'b10};
    logic [WB-1:0]  dat_t[2] = '{32'hBEEF_1234, 32'hAAAA_5555};
    logic [CB-1:0]  e10_t[2] = '{16'h1234, 16'h1234};
    logic [CB-1:0]  e11_t[2] = '{16'hBEEF, 16'hAAAA};
    for (int k = 0; k < 2; k++) begin
      out_ready = 1'b1;
      wr_en = en_t[k]; wr_bank = '0; wr_addr = WAB'(5); wr_data = dat_t[k];
      tick();
      wr_en = '0;
      in_valid = 1'b1; in_index = IDXB'(10);
      tick();
      in_index = IDXB'(11);
      n_checks++; if (out_valid !== 1'b0) $display("FAIL lane%0d_latency got=%b want=0", k, out_valid); else n_pass++;
      tick();
      in_valid = 1'b0;
      n_checks++; if (out_valid !== 1'b1 || out_color !== e10_t[k])
        $display("FAIL lane%0d_idx10 got=%b/%h want=1/%h", k, out_valid, out_color, e10_t[k]); else n_pass++;
      $display("write en=%b data=%h idx10 -> %h", en_t[k], dat_t[k], out_color);
      tick();
      n_checks++; if (out_valid !== 1'b1 || out_color !== e11_t[k])
        $display("FAIL lane%0d_idx11 got=%b/%h want=1/%h", k, out_valid, out_color, e11_t[k]); else n_pass++;
      $display("write en=%b data=%h idx11 -> %h", en_t[k], dat_t[k], out_color);
      tick();
      n_checks++; if (out_valid !== 1'b0) $display("FAIL lane%0d_drain got=%b want=0", k, out_valid); else n_pass++;
    end
  endtask

  task automatic test_stream_stall();
    logic [CB-1:0] colors [16];
    bit            pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int            sent = 0, recv = 0;
    bit            prev_stall = 0;
    logic [CB-1:0] prev_c = '0;
    for (int w = 0; w < 8; w++) begin
      wr_en = 2'b11; wr_bank = '0; wr_addr = WAB'(w); wr_data = $urandom;
      colors[2*w] = wr_data[15:0]; colors[2*w+1] = wr_data[31:16];
      tick();
    end
    wr_en = '0;
    for (int cyc = 0; cyc < 200 && recv < 16; cyc++) begin
      out_ready = pat[cyc % 4];
      in_valid  = (sent < 16);
      in_index  = IDXB'(sent);
      #1;
      n_checks++; if (in_ready !== (!out_valid || out_ready))
        $display("FAIL stream_in_ready cyc=%0d got=%b want=%b", cyc, in_ready, !out_valid || out_ready); else n_pass++;
      if (prev_stall) begin
        n_checks++; if (out_valid !== 1'b1 || out_color !== prev_c)
          $display("FAIL stream_hold cyc=%0d got=%b/%h want=1/%h", cyc, out_valid, out_color, prev_c); else n_pass++;
      end
      if (out_valid) begin
        n_checks++; if (out_color !== colors[recv])
          $display("FAIL stream_color n=%0d got=%h want=%h", recv, out_color, colors[recv]); else n_pass++;
        if (out_ready) begin
          $display("stream result %0d color=%h", recv, out_color);
          recv++;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_c     = out_color;
      if (in_valid && in_ready) sent++;
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n_checks++; if (recv != 16) $display("FAIL stream_count got=%0d want=16", recv); else n_pass++;
  endtask

  task automatic test_swap();
    logic [CB-1:0] c; logic t; bit ok;
    wr_en = 2'b10; wr_bank = 1'b0; wr_addr = WAB'(1); wr_data = 32'h0001_0000; tick();
    wr_bank = 1'b1; wr_data = 32'h0002_0000; tick();
    wr_en = '0;
    swap_req = 1'b1; swap_bank = 1'b1; tick(); swap_req = 1'b0;
    n_checks++; if ({active_bank, swap_pending} !== 2'b01)
      $display("FAIL swap_pend got=%b/%b want=0/1", active_bank, swap_pending); else n_pass++;
    lookup(3, c, t, ok);
    n_checks++; if (!ok || c !== 16'h0001) $display("FAIL swap_before got=%b/%h want=1/0001", ok, c); else n_pass++;
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    n_checks++; if ({active_bank, swap_pending} !== 2'b10)
      $display("FAIL swap_frame got=%b/%b want=1/0", active_bank, swap_pending); else n_pass++;
    lookup(3, c, t, ok);
    n_checks++; if (!ok || c !== 16'h0002) $display("FAIL swap_after got=%b/%h want=1/0002", ok, c); else n_pass++;
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    n_checks++; if ({active_bank, swap_pending} !== 2'b10)
      $display("FAIL swap_idle_frame got=%b/%b want=1/0", active_bank, swap_pending); else n_pass++;
  endtask

  task automatic test_same_cycle_transparency();
    logic [CB-1:0] c; logic t; bit ok;
    swap_req = 1'b1; swap_bank = 1'b0; frame_start = 1'b1; tick();
    n_checks++; if ({active_bank, swap_pending} !== 2'b00)
      $display("FAIL direct_swap0 got=%b/%b want=0/0", active_bank, swap_pending); else n_pass++;
    swap_bank = 1'b1; tick();
    swap_req = 1'b0; frame_start = 1'b0;
    n_checks++; if ({active_bank, swap_pending} !== 2'b10)
      $display("FAIL direct_swap1 got=%b/%b want=1/0", active_bank, swap_pending); else n_pass++;
    wr_en = 2'b11; wr_bank = 1'b1; wr_addr = '0; wr_data = 32'h2222_1111; tick(); wr_en = '0;
    transparent_en = 1'b1;
    lookup(0, c, t, ok);
    n_checks++; if (!ok || t !== 1'b1 || c !== 16'h1111)
      $display("FAIL transp_idx0 got=%b/%b/%h want=1/1/1111", ok, t, c); else n_pass++;
    lookup(1, c, t, ok);
    n_checks++; if (!ok || t !== 1'b0 || c !== 16'h2222)
      $display("FAIL transp_idx1 got=%b/%b/%h want=1/0/2222", ok, t, c); else n_pass++;
    transparent_en = 1'b0;
    lookup(0, c, t, ok);
    n_checks++; if (!ok || t !== 1'b0) $display("FAIL transp_disabled got=%b/%b want=1/0", ok, t); else n_pass++;
  endtask

  task automatic test_random();
    bit            prev_stall = 0;
    logic [CB-1:0] prev_c = '0;
    logic          prev_t = 1'b0;
    int            nres = 0;
    for (int w = 0; w < NB * PL / CPW; w++) begin
      wr_en = 2'b11; wr_bank = BB'(w / (PL / CPW)); wr_addr = WAB'(w); wr_data = $urandom;
      tick();
    end
    for (int cyc = 0; cyc < 1600; cyc++) begin
      swap_req       = ($urandom_range(0, 15) == 0);
      swap_bank      = BB'($urandom);
      frame_start    = ($urandom_range(0, 11) == 0);
      transparent_en = $urandom_range(0, 1);
      in_valid       = ($urandom_range(0, 3) != 0);
      in_index       = ($urandom_range(0, 3) == 0) ? '0 : IDXB'($urandom);
      out_ready      = ($urandom_range(0, 2) != 0);
      wr_en          = CPW'($urandom);
      wr_data        = $urandom;
      if ($urandom_range(0, 3) == 0) begin
        wr_bank = BB'(m_active); wr_addr = WAB'(in_index >> 1);
      end else begin
        wr_bank = BB'($urandom); wr_addr = WAB'($urandom);
      end
      #1;
      n_checks++; if (in_ready !== (!out_valid || out_ready))
        $display("FAIL rnd_in_ready cyc=%0d got=%b want=%b", cyc, in_ready, !out_valid || out_ready); else n_pass++;
      n_checks++; if (int'(active_bank) != m_active || swap_pending !== m_pending)
        $display("FAIL rnd_bank cyc=%0d got=%0d/%b want=%0d/%b", cyc, active_bank, swap_pending, m_active, m_pending); else n_pass++;
      if (prev_stall) begin
        n_checks++; if (out_valid !== 1'b1 || out_color !== prev_c || out_transparent !== prev_t)
          $display("FAIL rnd_hold cyc=%0d got=%b/%h want=1/%h", cyc, out_valid, out_color, prev_c); else n_pass++;
      end
      if (out_valid) begin
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL rnd_spurious cyc=%0d got=%h want=none", cyc, out_color);
        else if ((exp_q[0].known && out_color !== exp_q[0].c) || out_transparent !== exp_q[0].t)
          $display("FAIL rnd_result cyc=%0d got=%h/%b want=%h/%b", cyc, out_color, out_transparent, exp_q[0].c, exp_q[0].t);
        else n_pass++;
        if (out_ready) nres++;
      end
      prev_stall = out_valid && !out_ready;
      prev_c = out_color; prev_t = out_transparent;
      tick();
    end
    swap_req = 1'b0; frame_start = 1'b0; in_valid = 1'b0; out_ready = 1'b1; wr_en = '0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid) begin
        n_checks++; if (exp_q.size() == 0 || (exp_q[0].known && out_color !== exp_q[0].c))
          $display("FAIL rnd_drain got=%h want=%h", out_color, exp_q.size() ? exp_q[0].c : '0); else n_pass++;
        nres++;
      end
      tick();
    end
    n_checks++; if (exp_q.size() != 0) $display("FAIL rnd_leftover got=%0d want=0", exp_q.size()); else n_pass++;
    $display("random run delivered %0d results", nres);
  endtask

  task automatic test_reset_midflight();
    bit stale = 0;
    swap_req = 1'b1; swap_bank = 1'b1; tick(); swap_req = 1'b0;
    out_ready = 1'b0; in_valid = 1'b1; in_index = IDXB'(3);
    tick();
    in_index = IDXB'(4);
    tick();
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1 || swap_pending !== 1'b1)
      $display("FAIL midflight_setup got=%b/%b want=1/1", out_valid, swap_pending); else n_pass++;
    reset = 1'b1;
    #1;
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0)
      $display("FAIL midflight_reset_out got=%b/%b want=0/0", out_valid, in_ready); else n_pass++;
    n_checks++; if ({active_bank, swap_pending} !== 2'b00)
      $display("FAIL midflight_reset_bank got=%b/%b want=0/0", active_bank, swap_pending); else n_pass++;
    exp_q.delete(); m_active = 0; m_pbank = 0; m_pending = 0;
    tick(); tick();
    reset = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) stale = 1;
      tick();
    end
    n_checks++; if (stale) $display("FAIL midflight_stale got=1 want=0"); else n_pass++;
    $display("reset mid-flight: in-flight lookups discarded=%0b", !stale);
  endtask

  initial begin
    #2;
    test_reset();
    test_write_lanes();
    test_stream_stall();
    test_swap();
    test_same_cycle_transparency();
    test_random();
    test_reset_midflight();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end
endmodule
